multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Main control FSM for the multicycle RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, and supplies ALUOp to the ALU decoder, which combines ALUOp with funct3, funct7_5 and op5 into ALUControl. It also resolves all six branch conditions from the ALU Zero flag and stalls on a memory-ready handshake.

Parameters:
TRAP_STICKY, 1, 1 = TRAP holds until reset; 0 = TRAP returns to FETCH after one cycle (instruction skipped).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12] from instruction register
Zero  input  1  ALU result == 0
mem_ready  input  1  memory completes current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register and OldPC enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1, 11 zero
ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 const 4
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  output  1  register file write enable
ALUOp  output  2  00 add, 01 branch compare, 10 funct-decoded
illegal_instr  output  1  high while in TRAP
state_o  output  4  current state, for debug

Behaviour:
- State register updates on the rising edge of clk; reset is asynchronous and active-high and forces state to FETCH.
- While reset is high: PCWrite, IRWrite, MemWrite and RegWrite are all 0.
- Outputs are combinational from state. Exceptions: FETCH/MEMREAD/MEMWRITE gate on mem_ready, and BRANCH gates on Zero.
- Unlisted outputs are 0. ImmSrc is decoded from opcode in every state.
- PCWrite = PCUpdate | (Branch & taken).
- taken = Zero ^ funct3[0] ^ funct3[2]. This covers beq/bne/blt/bge/bltu/bgeu.
- States (4-bit encoding), with outputs and transitions:
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal mem_ready. Stays in FETCH while !mem_ready, else goes to DECODE.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut <= OldPC+imm). Dispatch on opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 (auipc) -> ALUWB
    - any other opcode -> TRAP
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. opcode[5]=0 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD(3): AdrSrc=1. Waits while !mem_ready, then -> MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE(5): AdrSrc=1, MemWrite=1, held until mem_ready, then -> FETCH.
  - EXECUTER(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - JALR(11): ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> JAL.
  - LUI(12): ALUSrcA=11, ALUSrcB=01, ALUOp=00 -> ALUWB.
  - TRAP(13): illegal_instr=1, all enables 0. Stays if TRAP_STICKY, else -> FETCH.
  - Codes 14-15 are unreachable; if entered, go to FETCH next cycle with all enables 0.
- Cycle counts with mem_ready always high:
  - lw 5
  - sw 4
  - R/I-type 4
  - branch 3
  - jal 4
  - jalr 5
  - lui 4
  - auipc 3
- Each memory wait cycle adds 1.
- Reset asserted mid-instruction: immediately FETCH, no partial write enables. After release, fetch resumes at the PC value held in the datapath.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - ALUOp codes
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings
- The ALU decoder consumes the same ALUOp constants from this package.
- One sub-module: branch_cond (funct3, Zero -> taken), reusable by a future pipelined core.

Test Plan:
- lw, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 with ResultSrc=01 only in cycle 5; IRWrite=1 only in cycle 1.
- sw with mem_ready low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH; RegWrite never 1.
- Branches, each in BRANCH state:
  - beq (funct3=000), Zero=1 -> PCWrite=1
  - bne (001), Zero=1 -> PCWrite=0
  - blt (100), Zero=0 -> PCWrite=1
  - bgeu (111), Zero=0 -> PCWrite=0
- addi (0010011) -> EXECUTEI with ALUOp=10, ALUSrcB=01, then ALUWB. jalr -> states 1,11,10,8 with PCWrite=1 in state 10.
- opcode 0000000 -> TRAP, illegal_instr=1 held for 10 cycles with TRAP_STICKY=1; single cycle, then FETCH, with TRAP_STICKY=0.
- reset asserted mid-MEMWRITE, asynchronous to clk -> state_o=0 and MemWrite=0 within the same cycle, no clock edge required.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALUOp codes and datapath mux select values.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // R-type has no immediate; it falls through to the I encoding.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       illegal_instr;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUOp, illegal_instr, state_o
    );

    modport slave (
        output opcode, funct3, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUOp, illegal_instr, state_o
    );

endinterface

// File: rtl/multicycle_control_fsm_branch_cond.sv
// Branch resolution from funct3 and the ALU Zero flag for all six RV32I branches.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       taken
);

    // funct3[0] inverts the sense (ne/ge); funct3[2] selects a less-than compare,
    // where Zero means "not less". funct3[1] (signedness) is the ALU's concern.
    logic unused_funct3_1;
    assign unused_funct3_1 = funct3[1];

    assign taken = zero ^ funct3[0] ^ funct3[2];

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/
// writeback sequencing, datapath selects, write enables and ALUOp.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit TRAP_STICKY = 1'b1
) (
    input logic                       clk,
    input logic                       reset,
    multicycle_control_fsm_if.master  ctrl
);

    state_t     state;
    state_t     state_next;

    logic       taken;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    branch_cond u_branch_cond (
        .funct3 (ctrl.funct3),
        .zero   (ctrl.Zero),
        .taken  (taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_ALUWB;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = ctrl.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_JALR:     state_next = S_JAL;
            S_LUI:      state_next = S_ALUWB;
            S_TRAP:     state_next = TRAP_STICKY ? S_TRAP : S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = ctrl.mem_ready;
                pc_update  = ctrl.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_BRANCH;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            S_TRAP:     illegal = 1'b1;
            default: ;
        endcase
    end

    // Enables are also gated by the raw reset so nothing writes while it is held.
    assign ctrl.PCWrite       = ~reset & (pc_update | (branch & taken));
    assign ctrl.IRWrite       = ~reset & ir_write;
    assign ctrl.MemWrite      = ~reset & mem_write;
    assign ctrl.RegWrite      = ~reset & reg_write;
    assign ctrl.AdrSrc        = adr_src;
    assign ctrl.ResultSrc     = result_src;
    assign ctrl.ALUSrcA       = alu_src_a;
    assign ctrl.ALUSrcB       = alu_src_b;
    assign ctrl.ALUOp         = alu_op;
    assign ctrl.ImmSrc        = imm_src_of(ctrl.opcode);
    assign ctrl.illegal_instr = illegal;
    assign ctrl.state_o       = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction reference paths
// push expected per-cycle controls; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic       rw;
        logic [1:0] aop;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic sel;
        exp_t e;
    } sb_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

    logic clk;
    logic rst_r;
    logic sel;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    int checks;
    int errors;
    sb_t q[$];

    multicycle_control_fsm_if bus0 ();
    multicycle_control_fsm_if bus1 ();

    multicycle_control_fsm #(.TRAP_STICKY(1'b1)) dut0 (.clk(clk), .reset(rst_r), .ctrl(bus0));
    multicycle_control_fsm #(.TRAP_STICKY(1'b0)) dut1 (.clk(clk), .reset(rst_r), .ctrl(bus1));

    exp_t act0, act1;
    assign act0 = {bus0.state_o, bus0.PCWrite, bus0.AdrSrc, bus0.MemWrite, bus0.IRWrite,
                   bus0.ResultSrc, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ImmSrc, bus0.RegWrite,
                   bus0.ALUOp, bus0.illegal_instr};
    assign act1 = {bus1.state_o, bus1.PCWrite, bus1.AdrSrc, bus1.MemWrite, bus1.IRWrite,
                   bus1.ResultSrc, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ImmSrc, bus1.RegWrite,
                   bus1.ALUOp, bus1.illegal_instr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 jalr, 7 lui, 8 auipc, 9 illegal
    function automatic int cls(input logic [6:0] op);
        case (op)
            LW: return 0;  SW: return 1;  RT: return 2;  IT: return 3;
            BR: return 4;  JL: return 5;  JR: return 6;  LU: return 7;
            AU: return 8;
            default: return 9;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (cls(op))
            1: return 3'b001;
            4: return 3'b010;
            5: return 3'b011;
            7, 8: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Branch outcome from the instruction's meaning: the ALU subtracts for eq/ne
    // (Zero = equal) and computes a less-than flag for lt/ge (Zero = not less).
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000: return z;
            3'b001: return !z;
            3'b100, 3'b110: return !z;
            3'b101, 3'b111: return z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t exp_out(input int s, input logic [6:0] op, input logic [2:0] f3,
                                     input logic mr, input logic z, input logic rst);
        exp_t e;
        e = '0;
        e.st  = 4'(s);
        e.imm = imm_of(op);
        case (s)
            0:  begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            3:  e.adr = 1'b1;
            4:  begin e.res = 2'b01; e.rw = 1'b1; end
            5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            6:  begin e.sa = 2'b10; e.aop = 2'b10; end
            7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            8:  e.rw = 1'b1;
            9:  begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = branch_taken(f3, z); end
            10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            11: begin e.sa = 2'b10; e.sb = 2'b01; end
            12: begin e.sa = 2'b11; e.sb = 2'b01; end
            13: e.ill = 1'b1;
            default: ;
        endcase
        if (rst) begin
            e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0;
        end
        return e;
    endfunction

    function automatic logic rz(input int zb);
        return (zb >= 0) ? zb[0] : logic'($urandom_range(0, 1));
    endfunction

    function automatic logic rmr();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input int s, input logic mr, input logic z, input logic rst);
        sb_t item;
        @(posedge clk);
        #1;
        rst_r = rst;
        bus0.mem_ready = mr;  bus1.mem_ready = mr;
        bus0.Zero = z;        bus1.Zero = z;
        bus0.opcode = cur_op; bus1.opcode = cur_op;
        bus0.funct3 = cur_f3; bus1.funct3 = cur_f3;
        item.sel = sel;
        item.e = exp_out(s, cur_op, cur_f3, mr, z, rst);
        q.push_back(item);
    endtask

    task automatic memwait(input int s, input int mw, input int zb);
        int w;
        w = (mw >= 0) ? mw : int'($urandom_range(0, 2));
        repeat (w) cyc(s, 1'b0, rz(zb), 1'b0);
        cyc(s, 1'b1, rz(zb), 1'b0);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int mw,
                             input int zb, input logic sticky);
        int fw;
        cur_op = op;
        cur_f3 = f3;
        fw = (mw >= 0) ? 0 : int'($urandom_range(0, 2));
        repeat (fw) cyc(0, 1'b0, rz(zb), 1'b0);
        cyc(0, 1'b1, rz(zb), 1'b0);
        cyc(1, rmr(), rz(zb), 1'b0);
        case (cls(op))
            0: begin cyc(2, rmr(), rz(zb), 1'b0); memwait(3, mw, zb); cyc(4, rmr(), rz(zb), 1'b0); end
            1: begin cyc(2, rmr(), rz(zb), 1'b0); memwait(5, mw, zb); end
            2: begin cyc(6, rmr(), rz(zb), 1'b0); cyc(8, rmr(), rz(zb), 1'b0); end
            3: begin cyc(7, rmr(), rz(zb), 1'b0); cyc(8, rmr(), rz(zb), 1'b0); end
            4: cyc(9, rmr(), rz(zb), 1'b0);
            5: begin cyc(10, rmr(), rz(zb), 1'b0); cyc(8, rmr(), rz(zb), 1'b0); end
            6: begin cyc(11, rmr(), rz(zb), 1'b0); cyc(10, rmr(), rz(zb), 1'b0); cyc(8, rmr(), rz(zb), 1'b0); end
            7: begin cyc(12, rmr(), rz(zb), 1'b0); cyc(8, rmr(), rz(zb), 1'b0); end
            8: cyc(8, rmr(), rz(zb), 1'b0);
            default: begin
                if (sticky) begin
                    repeat (10) cyc(13, rmr(), rz(zb), 1'b0);
                    cyc(0, rmr(), rz(zb), 1'b1);
                end else begin
                    cyc(13, rmr(), rz(zb), 1'b0);
                end
            end
        endcase
    endtask

    task automatic run_random(input logic sticky);
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] br_f3 [6];
        br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        f3 = 3'($urandom);
        case ($urandom_range(0, 19))
            0, 1:       op = LW;
            2, 3:       op = SW;
            4, 5, 15:   op = RT;
            6, 7, 16:   op = IT;
            8, 9, 10, 17: begin op = BR; f3 = br_f3[$urandom_range(0, 5)]; end
            11, 18:     op = JL;
            12:         op = JR;
            13:         op = LU;
            14:         op = AU;
            default: begin
                op = 7'($urandom);
                while (cls(op) != 9) op = 7'($urandom);
            end
        endcase
        run_instr(op, f3, -1, -1, sticky);
    endtask

    always @(negedge clk) begin
        sb_t item;
        exp_t a;
        if (q.size() > 0) begin
            item = q.pop_front();
            a = item.sel ? act1 : act0;
            checks++;
            if (a !== item.e) begin
                errors++;
                $display("FAIL ctrl dut%0d t=%0t: actual=%h (state %0d) required=%h (state %0d)",
                         item.sel, $time, a, a.st, item.e, item.e.st);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        sel = 1'b0;
        rst_r = 1'b1;
        cur_op = LW;
        cur_f3 = 3'b000;
        bus0.opcode = LW; bus0.funct3 = '0; bus0.Zero = 1'b0; bus0.mem_ready = 1'b0;
        bus1.opcode = LW; bus1.funct3 = '0; bus1.Zero = 1'b0; bus1.mem_ready = 1'b0;

        cyc(0, 1'b1, 1'b0, 1'b1);
        run_instr(LW, 3'b010, 0, -1, 1'b1);
        run_instr(SW, 3'b010, 2, -1, 1'b1);
        run_instr(BR, 3'b000, 0, 1, 1'b1);
        run_instr(BR, 3'b001, 0, 1, 1'b1);
        run_instr(BR, 3'b100, 0, 0, 1'b1);
        run_instr(BR, 3'b111, 0, 0, 1'b1);
        run_instr(IT, 3'b000, 0, -1, 1'b1);
        run_instr(JR, 3'b000, 0, -1, 1'b1);
        run_instr(7'b0000000, 3'b000, 0, -1, 1'b1);

        // Asynchronous reset in the middle of a stalled store
        cur_op = SW;
        cur_f3 = 3'b010;
        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 1'b0);
        cyc(2, 1'b1, 1'b0, 1'b0);
        cyc(5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_r = 1'b1;
        #1;
        chk("async_rst_state", bus0.state_o, 4'd0);
        chk("async_rst_memwrite", {3'b0, bus0.MemWrite}, 4'd0);
        chk("async_rst_enables", {bus0.PCWrite, bus0.IRWrite, bus0.RegWrite, bus0.MemWrite}, 4'd0);
        cyc(0, 1'b1, 1'b0, 1'b1);

        repeat (150) run_random(1'b1);

        sel = 1'b1;
        cyc(0, 1'b1, 1'b0, 1'b1);
        run_instr(7'b0000000, 3'b000, 0, -1, 1'b0);
        run_instr(AU, 3'b000, 0, -1, 1'b0);
        repeat (40) run_random(1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d required=0 entries left", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
